// File: rtl/rom_arbiter.sv
// Cart ROM arbiter: buffers the download byte stream in a small FIFO and shares
// one memory port between download writes and CPU cartridge reads.
module rom_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_SYS,
  input  logic        RST_N,
  input  logic        DL_ACTIVE,
  input  logic        DL_SEL_CART,
  input  logic [16:0] DL_ADDR,
  input  logic [7:0]  DL_DATA,
  input  logic        DL_VALID,
  output logic        DL_WAIT,
  output logic        DL_DONE,
  output logic        DL_OVF,
  input  logic        RD_REQ,
  input  logic [16:0] RD_ADDR,
  output logic [7:0]  RD_DATA,
  output logic        RD_ACK,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [16:0] MEM_ADDR,
  output logic [7:0]  MEM_DIN,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_DOUT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;
  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  localparam logic G_READ  = 1'b0;
  localparam logic G_WRITE = 1'b1;

  state_e            state_q, state_d;
  dl_entry_t         fifo_mem_q [FIFO_DEPTH];
  dl_entry_t         fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [16:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d, rd_data_q, rd_data_d;
  logic              rd_ack_q, rd_ack_d;
  logic              dl_done_q, dl_done_d, dl_ovf_q, dl_ovf_d;
  logic              dl_seen_q, dl_seen_d, dl_active_q, dl_active_d;

  logic      dl_hit, fifo_full, fifo_empty, push, drop, pop;
  logic      wr_pend, rd_pend, grant_wr, grant_rd, mem_ack, dl_rise, done_fire;
  dl_entry_t head;

  assign dl_hit     = DL_VALID && DL_SEL_CART;
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = dl_hit && !fifo_full;
  assign drop       = dl_hit && fifo_full;
  assign head       = fifo_mem_q[rd_ptr_q];
  // Raised one entry early so the byte already in flight still fits.
  assign DL_WAIT    = (count_q >= CW'(FIFO_DEPTH - 1));

  assign wr_pend  = !fifo_empty;
  assign rd_pend  = RD_REQ && !rd_ack_q;
  assign mem_ack  = MEM_ACK && mem_req_q;
  assign grant_wr = (state_q == IDLE) && wr_pend && (!rd_pend || (last_grant_q == G_READ));
  assign grant_rd = (state_q == IDLE) && rd_pend && !grant_wr;

  assign dl_rise   = DL_ACTIVE && !dl_active_q;
  assign done_fire = !DL_ACTIVE && fifo_empty && !push && (state_q == IDLE) && dl_seen_q;

  always_ff @(posedge CLK_SYS or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_wr)      state_d = WRITE;
        else if (grant_rd) state_d = READ;
      end
      WRITE, READ: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    rd_data_d    = rd_data_q;
    rd_ack_d     = 1'b0;
    last_grant_d = last_grant_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = head.addr;
          mem_din_d  = head.data;
        end else if (grant_rd) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = RD_ADDR;
          mem_din_d  = 8'h00;
        end
      end
      WRITE: if (mem_ack) begin
        mem_req_d    = 1'b0;
        pop          = 1'b1;
        last_grant_d = G_WRITE;
      end
      READ: if (mem_ack) begin
        mem_req_d    = 1'b0;
        rd_data_d    = MEM_DOUT;
        rd_ack_d     = 1'b1;
        last_grant_d = G_READ;
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = '{addr: DL_ADDR, data: DL_DATA};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    dl_active_d = DL_ACTIVE;
    dl_done_d   = done_fire;
    dl_ovf_d    = (dl_ovf_q && !dl_rise) || drop;
    // A download is "seen" from activity until its matching done pulse.
    if (DL_ACTIVE || push) dl_seen_d = 1'b1;
    else if (done_fire)    dl_seen_d = 1'b0;
    else                   dl_seen_d = dl_seen_q;
  end

  always_ff @(posedge CLK_SYS or negedge RST_N) begin
    if (!RST_N) begin
      fifo_mem_q   <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= G_READ;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      rd_data_q    <= '0;
      rd_ack_q     <= 1'b0;
      dl_done_q    <= 1'b0;
      dl_ovf_q     <= 1'b0;
      dl_seen_q    <= 1'b0;
      dl_active_q  <= 1'b0;
    end else begin
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      rd_data_q    <= rd_data_d;
      rd_ack_q     <= rd_ack_d;
      dl_done_q    <= dl_done_d;
      dl_ovf_q     <= dl_ovf_d;
      dl_seen_q    <= dl_seen_d;
      dl_active_q  <= dl_active_d;
    end
  end

  assign MEM_REQ  = mem_req_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DIN  = mem_din_q;
  assign RD_DATA  = rd_data_q;
  assign RD_ACK   = rd_ack_q;
  assign DL_DONE  = dl_done_q;
  assign DL_OVF   = dl_ovf_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: reset, reads, download FIFO, contention,
// drain/done, filtering and reset during a transaction.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl_active, dl_sel, dl_valid;
  logic [16:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait, dl_done, dl_ovf;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic        mem_req, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic [7:0]  mem_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.FIFO_DEPTH(4)) dut (
    .CLK_SYS(clk), .RST_N(rst_n),
    .DL_ACTIVE(dl_active), .DL_SEL_CART(dl_sel), .DL_ADDR(dl_addr),
    .DL_DATA(dl_data), .DL_VALID(dl_valid),
    .DL_WAIT(dl_wait), .DL_DONE(dl_done), .DL_OVF(dl_ovf),
    .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_ACK(rd_ack),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_DIN(mem_din),
    .MEM_ACK(mem_ack), .MEM_DOUT(mem_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dl_active = 0; dl_sel = 0; dl_valid = 0; dl_addr = '0; dl_data = '0;
    rd_req = 0; rd_addr = '0; mem_ack = 0; mem_dout = '0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0h exp=0", mem_we); end
    checks++; if (mem_addr !== 17'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_din !== 8'h0) begin failures++; $display("FAIL rst_mem_din got=%0h exp=0", mem_din); end
    checks++; if (rd_data !== 8'h0) begin failures++; $display("FAIL rst_rd_data got=%0h exp=0", rd_data); end
    checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rst_rd_ack got=%0h exp=0", rd_ack); end
    checks++; if (dl_done !== 1'b0) begin failures++; $display("FAIL rst_dl_done got=%0h exp=0", dl_done); end
    checks++; if (dl_ovf !== 1'b0) begin failures++; $display("FAIL rst_dl_ovf got=%0h exp=0", dl_ovf); end
    checks++; if (dl_wait !== 1'b0) begin failures++; $display("FAIL rst_dl_wait got=%0h exp=0", dl_wait); end
    rst_n = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL post_rst_mem_req got=%0h exp=0", mem_req); end
    checks++; if (dl_done !== 1'b0) begin failures++; $display("FAIL post_rst_dl_done got=%0h exp=0", dl_done); end
  endtask

  task automatic test_read();
    mem_ack = 1'b1; mem_dout = 8'hEE;
    tick();
    mem_ack = 1'b0;
    checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL stray_ack_rd_ack got=%0h exp=0", rd_ack); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL stray_ack_rd_data got=%0h exp=00", rd_data); end
    rd_req = 1'b1; rd_addr = 17'h00123;
    tick();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rd_mem_req got=%0h exp=1", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%0h exp=0", mem_we); end
    checks++; if (mem_addr !== 17'h00123) begin failures++; $display("FAIL rd_mem_addr got=%0h exp=00123", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin failures++; $display("FAIL rd_mem_din got=%0h exp=00", mem_din); end
    tick(); tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 17'h00123) begin failures++; $display("FAIL rd_hold got=%0h/%0h exp=1/00123", mem_req, mem_addr); end
    checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%0h exp=0", rd_ack); end
    mem_ack = 1'b1; mem_dout = 8'h5A;
    tick();
    mem_ack = 1'b0; rd_req = 1'b0;
    checks++; if (rd_ack !== 1'b1) begin failures++; $display("FAIL rd_ack got=%0h exp=1", rd_ack); end
    checks++; if (rd_data !== 8'h5A) begin failures++; $display("FAIL rd_data got=%0h exp=5a", rd_data); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rd_req_drop got=%0h exp=0", mem_req); end
    tick();
    checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_width got=%0h exp=0", rd_ack); end
    checks++; if (rd_data !== 8'h5A) begin failures++; $display("FAIL rd_data_hold got=%0h exp=5a", rd_data); end
  endtask

  task automatic test_burst();
    logic exp_wait;
    dl_active = 1'b1; dl_sel = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      dl_valid = 1'b1; dl_addr = 17'(i); dl_data = 8'hA0 + 8'(i);
      tick();
      exp_wait = (i >= 2);
      checks++; if (dl_wait !== exp_wait) begin failures++; $display("FAIL burst_wait[%0d] got=%0h exp=%0h", i, dl_wait, exp_wait); end
      checks++; if (dl_ovf !== (i == 4)) begin failures++; $display("FAIL burst_ovf[%0d] got=%0h exp=%0h", i, dl_ovf, (i == 4)); end
    end
    dl_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL burst_wr_req[%0d] got=%0h/%0h exp=1/1", i, mem_req, mem_we); end
      checks++; if (mem_addr !== 17'(i)) begin failures++; $display("FAIL burst_wr_addr[%0d] got=%0h exp=%0h", i, mem_addr, i); end
      checks++; if (mem_din !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL burst_wr_din[%0d] got=%0h exp=%0h", i, mem_din, 8'hA0 + 8'(i)); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL burst_req_drop[%0d] got=%0h exp=0", i, mem_req); end
      tick();
    end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL burst_dropped_byte_written got=%0h exp=0", mem_req); end
    checks++; if (dl_wait !== 1'b0) begin failures++; $display("FAIL burst_wait_empty got=%0h exp=0", dl_wait); end
    dl_active = 1'b0;
    tick();
    checks++; if (dl_done !== 1'b1) begin failures++; $display("FAIL burst_done got=%0h exp=1", dl_done); end
    tick();
    checks++; if (dl_done !== 1'b0) begin failures++; $display("FAIL burst_done_width got=%0h exp=0", dl_done); end
    checks++; if (dl_ovf !== 1'b1) begin failures++; $display("FAIL burst_ovf_sticky got=%0h exp=1", dl_ovf); end
    dl_active = 1'b1;
    tick();
    checks++; if (dl_ovf !== 1'b0) begin failures++; $display("FAIL burst_ovf_clear got=%0h exp=0", dl_ovf); end
  endtask

  task automatic test_contention();
    logic        is_wr;
    logic [16:0] e_addr;
    logic [7:0]  e_din;
    rd_req = 1'b1; rd_addr = 17'h0ABCD;
    tick();
    mem_ack = 1'b1; mem_dout = 8'h3C;
    tick();
    mem_ack = 1'b0; rd_req = 1'b0;
    checks++; if (rd_ack !== 1'b1 || rd_data !== 8'h3C) begin failures++; $display("FAIL cont_pre_read got=%0h/%0h exp=1/3c", rd_ack, rd_data); end
    tick();
    dl_sel = 1'b1; dl_valid = 1'b1; dl_addr = 17'h10; dl_data = 8'hB0;
    tick();
    dl_addr = 17'h11; dl_data = 8'hB1; rd_req = 1'b1; rd_addr = 17'h0ABCD;
    tick();
    dl_addr = 17'h12; dl_data = 8'hB2;
    tick();
    dl_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      is_wr  = (i % 2 == 0);
      e_addr = is_wr ? 17'h10 + 17'(i / 2) : 17'h0ABCD;
      e_din  = is_wr ? 8'hB0 + 8'(i / 2) : 8'h00;
      checks++; if (mem_req !== 1'b1 || mem_we !== is_wr) begin failures++; $display("FAIL cont_grant[%0d] req/we got=%0h/%0h exp=1/%0h", i, mem_req, mem_we, is_wr); end
      checks++; if (mem_addr !== e_addr || mem_din !== e_din) begin failures++; $display("FAIL cont_fields[%0d] got=%0h/%0h exp=%0h/%0h", i, mem_addr, mem_din, e_addr, e_din); end
      mem_ack = 1'b1; mem_dout = 8'hC0 + 8'(i);
      tick();
      mem_ack = 1'b0;
      checks++; if (rd_ack !== !is_wr) begin failures++; $display("FAIL cont_rd_ack[%0d] got=%0h exp=%0h", i, rd_ack, !is_wr); end
      if (!is_wr) begin
        checks++; if (rd_data !== 8'hC0 + 8'(i)) begin failures++; $display("FAIL cont_rd_data[%0d] got=%0h exp=%0h", i, rd_data, 8'hC0 + 8'(i)); end
      end
      if (i == 5) rd_req = 1'b0;
      tick();
      checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL cont_rd_ack_width[%0d] got=%0h exp=0", i, rd_ack); end
    end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cont_idle got=%0h exp=0", mem_req); end
  endtask

  task automatic test_drain();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      dl_valid = 1'b1; dl_addr = 17'h1FFFD + 17'(i); dl_data = 8'hD0 + 8'(i);
      tick();
    end
    dl_valid = 1'b0; dl_active = 1'b0;
    tick();
    checks++; if (dl_done !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL drain_start done/req got=%0h/%0h exp=0/1", dl_done, mem_req); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_we !== 1'b1 || mem_addr !== 17'h1FFFD + 17'(i)) begin failures++; $display("FAIL drain_addr[%0d] got=%0h/%0h exp=1/%0h", i, mem_we, mem_addr, 17'h1FFFD + 17'(i)); end
      checks++; if (mem_din !== 8'hD0 + 8'(i)) begin failures++; $display("FAIL drain_din[%0d] got=%0h exp=%0h", i, mem_din, 8'hD0 + 8'(i)); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++; if (dl_done !== 1'b0) begin failures++; $display("FAIL drain_done_early[%0d] got=%0h exp=0", i, dl_done); end
      tick();
      if (dl_done === 1'b1) pulses++;
      checks++; if (dl_done !== (i == 2)) begin failures++; $display("FAIL drain_done[%0d] got=%0h exp=%0h", i, dl_done, (i == 2)); end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dl_done === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL drain_done_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_filter();
    dl_sel = 1'b0; dl_active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dl_valid = 1'b1; dl_addr = 17'h00200 + 17'(i); dl_data = 8'h11;
      tick();
      checks++; if (mem_req !== 1'b0 || dl_wait !== 1'b0) begin failures++; $display("FAIL filter[%0d] req/wait got=%0h/%0h exp=0/0", i, mem_req, dl_wait); end
    end
    dl_valid = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0 || dl_ovf !== 1'b0 || dl_done !== 1'b0) begin failures++; $display("FAIL filter_after req/ovf/done got=%0h/%0h/%0h exp=0/0/0", mem_req, dl_ovf, dl_done); end
  endtask

  task automatic test_reset_mid();
    rd_req = 1'b1; rd_addr = 17'h0F0F0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rmid_start req/we got=%0h/%0h exp=1/0", mem_req, mem_we); end
    dl_active = 1'b1; dl_sel = 1'b1; dl_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dl_addr = 17'h00100 + 17'(i); dl_data = 8'h60 + 8'(i);
      tick();
    end
    dl_valid = 1'b0;
    checks++; if (dl_wait !== 1'b1) begin failures++; $display("FAIL rmid_wait_full got=%0h exp=1", dl_wait); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmid_req_async got=%0h exp=0", mem_req); end
    checks++; if (dl_wait !== 1'b0) begin failures++; $display("FAIL rmid_wait_async got=%0h exp=0", dl_wait); end
    dl_active = 1'b0; mem_ack = 1'b1; mem_dout = 8'h99;
    tick(); tick();
    checks++; if (rd_ack !== 1'b0 || rd_data !== 8'h00 || mem_req !== 1'b0) begin failures++; $display("FAIL rmid_in_reset ack/data/req got=%0h/%0h/%0h exp=0/00/0", rd_ack, rd_data, mem_req); end
    mem_ack = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h0F0F0) begin failures++; $display("FAIL rmid_resume req/we/addr got=%0h/%0h/%0h exp=1/0/0f0f0", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_dout = 8'h77;
    tick();
    mem_ack = 1'b0; rd_req = 1'b0;
    checks++; if (rd_ack !== 1'b1 || rd_data !== 8'h77) begin failures++; $display("FAIL rmid_read ack/data got=%0h/%0h exp=1/77", rd_ack, rd_data); end
    tick(); tick();
    checks++; if (mem_req !== 1'b0 || rd_ack !== 1'b0) begin failures++; $display("FAIL rmid_no_leftover req/ack got=%0h/%0h exp=0/0", mem_req, rd_ack); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_burst();
    test_contention();
    test_drain();
    test_filter();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
